// File: rtl/sctag_scbuf_rptr_pipe.sv
// Flopped sctag<->scbuf repeater: valid-qualified forward data, reverse error flags, saturating error counter.
// Latency NSTAGE cycles both directions; no backpressure, one beat per cycle. Optional parity: SCTAG_SCBUF_RPTR_PARITY_EN.
module sctag_scbuf_rptr_pipe #(
  parameter int DW     = 78,
  parameter int EW     = 4,
  parameter int NSTAGE = 2,
  parameter int CW     = 8
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          fwd_vld_in,
  input  logic [DW-1:0] fwd_data_in,
  output logic          fwd_vld_out,
  output logic [DW-1:0] fwd_data_out,
  input  logic [EW-1:0] rev_err_in,
  output logic [EW-1:0] rev_err_out,
  input  logic          err_cnt_clr,
  output logic [CW-1:0] err_cnt,
  output logic          err_cnt_sat,
  output logic          par_err
);

  localparam logic [CW-1:0] CMAX = '1;

  logic          w_vld  [0:NSTAGE];
  logic [DW-1:0] w_data [0:NSTAGE];
  logic [EW-1:0] w_rev  [0:NSTAGE];

  assign w_vld[0]  = fwd_vld_in;
  assign w_data[0] = fwd_data_in;
  assign w_rev[0]  = rev_err_in;

  // Data only loads on a valid beat so idle cycles do not toggle the wide bus.
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    logic          r_vld;
    logic [DW-1:0] r_data;
    logic [EW-1:0] r_rev;

    always_ff @(posedge rclk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_data <= '0;
        r_rev  <= '0;
      end else begin
        r_vld <= w_vld[k-1];
        if (w_vld[k-1]) begin
          r_data <= w_data[k-1];
        end
        r_rev <= w_rev[k-1];
      end
    end

    assign w_vld[k]  = r_vld;
    assign w_data[k] = r_data;
    assign w_rev[k]  = r_rev;
  end

  assign fwd_vld_out  = w_vld[NSTAGE];
  assign fwd_data_out = w_data[NSTAGE];
  assign rev_err_out  = w_rev[NSTAGE];

  logic          w_evt;
  logic [CW-1:0] r_cnt;
  logic          r_sat;

  assign w_evt = |rev_err_out;

  always_ff @(posedge rclk) begin
    if (rst || err_cnt_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_evt && (r_cnt != CMAX)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == (CMAX - 1'b1)) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign err_cnt     = r_cnt;
  assign err_cnt_sat = r_sat;

`ifdef SCTAG_SCBUF_RPTR_PARITY_EN
  logic w_par [0:NSTAGE];
  logic r_par_err;

  assign w_par[0] = ^fwd_data_in;

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_par
    logic r_par;

    always_ff @(posedge rclk) begin
      if (rst) begin
        r_par <= 1'b0;
      end else if (w_vld[k-1]) begin
        r_par <= w_par[k-1];
      end
    end

    assign w_par[k] = r_par;
  end

  // Clear takes priority over a mismatch seen in the same cycle.
  always_ff @(posedge rclk) begin
    if (rst || err_cnt_clr) begin
      r_par_err <= 1'b0;
    end else if (fwd_vld_out && ((^fwd_data_out) != w_par[NSTAGE])) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sctag_scbuf_rptr_pipe.sv
// Bench for sctag_scbuf_rptr_pipe: driver records expectations per cycle, a negedge monitor
// compares outputs against a cycle-indexed reference model and a beat scoreboard.
module tb_sctag_scbuf_rptr_pipe;

  localparam int DW     = 78;
  localparam int EW     = 4;
  localparam int NSTAGE = 2;
  localparam int CW     = 2;
  localparam int MAXC   = 4096;
  localparam int CMAXI  = (1 << CW) - 1;

  logic          rclk = 1'b0;
  logic          rst;
  logic          fwd_vld_in;
  logic [DW-1:0] fwd_data_in;
  logic          fwd_vld_out;
  logic [DW-1:0] fwd_data_out;
  logic [EW-1:0] rev_err_in;
  logic [EW-1:0] rev_err_out;
  logic          err_cnt_clr;
  logic [CW-1:0] err_cnt;
  logic          err_cnt_sat;
  logic          par_err;

  sctag_scbuf_rptr_pipe #(.DW(DW), .EW(EW), .NSTAGE(NSTAGE), .CW(CW)) dut (
    .rclk        (rclk),
    .rst         (rst),
    .fwd_vld_in  (fwd_vld_in),
    .fwd_data_in (fwd_data_in),
    .fwd_vld_out (fwd_vld_out),
    .fwd_data_out(fwd_data_out),
    .rev_err_in  (rev_err_in),
    .rev_err_out (rev_err_out),
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt),
    .err_cnt_sat (err_cnt_sat),
    .par_err     (par_err)
  );

  initial forever #5 rclk = ~rclk;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         exp_q[$];
  logic [EW-1:0] rev_hist [0:MAXC-1];
  logic          clr_hist [0:MAXC-1];
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] last_d = '0;
  int            m_cnt  = 0;

  always @(posedge rclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [EW-1:0] r, input logic c);
    fwd_vld_in  = v;
    fwd_data_in = d;
    rev_err_in  = r;
    err_cnt_clr = c;
    rev_hist[cyc] = r;
    clr_hist[cyc] = c;
    if (v) exp_q.push_back('{c: cyc + NSTAGE, d: d});
    @(posedge rclk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: beat scoreboard on the forward path, cycle-indexed model on the reverse path.
  always @(negedge rclk) begin
    if (mon_en) begin
      logic [EW-1:0] er;
      beat_t b;
      if (fwd_vld_out) begin
        if (exp_q.size() == 0) chk("fwd_unexpected", fwd_vld_out, 1'b0);
        else begin
          b = exp_q.pop_front();
          chk("fwd_cycle", cyc, b.c);
          chk("fwd_data", fwd_data_out, b.d);
          last_d = b.d;
        end
      end else begin
        chk("fwd_hold", fwd_data_out, last_d);
        if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
          chk("fwd_missing", fwd_vld_out, 1'b1);
          void'(exp_q.pop_front());
        end
      end
      er = (cyc >= NSTAGE) ? rev_hist[cyc - NSTAGE] : '0;
      chk("rev_err_out", rev_err_out, er);
      chk("err_cnt", err_cnt, m_cnt);
      chk("err_cnt_sat", err_cnt_sat, (m_cnt == CMAXI));
      chk("par_err", par_err, 1'b0);
      if (clr_hist[cyc]) m_cnt = 0;
      else if (er != '0 && m_cnt < CMAXI) m_cnt = m_cnt + 1;
    end
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      rev_hist[i] = '0;
      clr_hist[i] = 1'b0;
    end
    rst         = 1'b1;
    fwd_vld_in  = 1'b1;
    fwd_data_in = rnd_data();
    rev_err_in  = 4'hF;
    err_cnt_clr = 1'b0;

    @(negedge rclk);
    chk("rst_vld", fwd_vld_out, 1'b0);
    chk("rst_data", fwd_data_out, '0);
    chk("rst_rev", rev_err_out, '0);
    chk("rst_cnt", err_cnt, '0);
    chk("rst_sat", err_cnt_sat, 1'b0);
    chk("rst_par", par_err, 1'b0);
    fwd_data_in = rnd_data();
    rev_err_in  = EW'($urandom());
    @(posedge rclk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (10) idle();

    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), '0, 1'b0);
    repeat (4) idle();

    drive(1'b1, DW'(8'hA5), '0, 1'b0);
    repeat (4) drive(1'b0, DW'(8'h3C), '0, 1'b0);
    repeat (2) idle();

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 4'b0011, 1'b0);
      repeat (3) idle();
    end

    drive(1'b0, '0, 4'b0101, 1'b0);
    repeat (NSTAGE - 1) idle();
    drive(1'b0, '0, '0, 1'b1);
    repeat (4) idle();

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), rnd_data(),
            ($urandom_range(0, 2) == 0) ? EW'($urandom()) : '0,
            ($urandom_range(0, 15) == 0));
    end
    repeat (NSTAGE + 2) idle();
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

`ifdef SCTAG_SCBUF_RPTR_PARITY_EN
    begin
      logic [DW-1:0] pd;
      pd = rnd_data();
      drive(1'b1, pd, '0, 1'b0);
      repeat (NSTAGE - 1) idle();
      force dut.g_stage[NSTAGE].r_data = pd ^ DW'(1);
      idle();
      release dut.g_stage[NSTAGE].r_data;
      chk("par_set", par_err, 1'b1);
      repeat (3) idle();
      chk("par_sticky", par_err, 1'b1);
      drive(1'b0, '0, '0, 1'b1);
      chk("par_clr", par_err, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
